// File: rtl/polaris_plic_gen2.sv
// rtl/polaris_plic_gen2.sv - TileLink-UL platform-level interrupt controller; optional edge triggers via PLIC_EDGE_TRIGGER_EN
module polaris_plic_gen2 #(
  parameter int TL_RS  = 4,
  parameter int NSRC   = 31,
  parameter int NCTX   = 2,
  parameter int PRIO_W = 3
) (
  input  logic             plic_clock_i,
  input  logic             plic_reset_ni,
  input  logic [2:0]       plic_a_opcode,
  input  logic [2:0]       plic_a_param,
  input  logic [3:0]       plic_a_size,
  input  logic [TL_RS-1:0] plic_a_source,
  input  logic [21:0]      plic_a_address,
  input  logic [3:0]       plic_a_mask,
  input  logic [31:0]      plic_a_data,
  input  logic             plic_a_corrupt,
  input  logic             plic_a_valid,
  output logic             plic_a_ready,
  output logic [2:0]       plic_d_opcode,
  output logic [1:0]       plic_d_param,
  output logic [3:0]       plic_d_size,
  output logic [TL_RS-1:0] plic_d_source,
  output logic             plic_d_denied,
  output logic [31:0]      plic_d_data,
  output logic             plic_d_corrupt,
  output logic             plic_d_valid,
  input  logic             plic_d_ready,
  input  logic [NSRC-1:0]  int_i,
  output logic [NCTX-1:0]  int_o
);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  // Architectural state; vectors indexed by source id, bit 0 (id 0) does not exist
  logic [PRIO_W-1:0] prio_q [1:NSRC];
  logic [NSRC:1]     en_q   [NCTX];
  logic [PRIO_W-1:0] thr_q  [NCTX];
  logic [NSRC:1]     pend_q, serv_q, pend_d, serv_d;
  logic [5:0]        best_id_q [NCTX];
  logic [PRIO_W-1:0] best_pr_q [NCTX];
  logic [5:0]        best_id_d [NCTX];
  logic [PRIO_W-1:0] best_pr_d [NCTX];
`ifdef PLIC_EDGE_TRIGGER_EN
  logic [NSRC:1]     trig_q, defer_q, defer_d;
  logic [NSRC-1:0]   int_prev_q, rise;
`endif

  // Response register
  logic             d_valid_q;
  logic [2:0]       d_opcode_q;
  logic [3:0]       d_size_q;
  logic [TL_RS-1:0] d_source_q;
  logic             d_denied_q;
  logic [31:0]      d_data_q;

  // Request decode
  logic       is_get, is_put, req_ok, accept, denied, readable, writable;
  logic       sel_prio, sel_pend, sel_trig, sel_en, sel_thr, sel_claim;
  logic       wr, rd_claim, cmpl, hi_word;
  logic [9:0] prio_id;
  logic [4:0] en_ctx;
  logic [2:0] th_ctx;
  logic [5:0] claim_id, cmpl_id;
  logic [31:0] rdata;
  logic [63:0] pend64, en64, trig64;
  logic [PRIO_W-1:0] prio_sel, thr_sel;
  logic [NSRC:1] cmpl_en, claim_hit, cmpl_hit;

  assign plic_a_ready = !d_valid_q || plic_d_ready;
  assign accept       = plic_a_valid && plic_a_ready;

  assign is_get  = plic_a_opcode == OP_GET;
  assign is_put  = (plic_a_opcode == OP_PUT_FULL) || (plic_a_opcode == OP_PUT_PART);
  assign req_ok  = (plic_a_param == 3'd0) && !plic_a_corrupt && (plic_a_address[1:0] == 2'b00);
  assign prio_id = plic_a_address[11:2];
  assign en_ctx  = plic_a_address[11:7];
  assign th_ctx  = plic_a_address[14:12];
  assign hi_word = plic_a_address[2];
  assign cmpl_id = plic_a_data[5:0];

  assign sel_prio  = (plic_a_address[21:12] == 10'h000) && (int'(prio_id) <= NSRC);
  assign sel_pend  = plic_a_address[21:3] == 19'h00200;
  assign sel_trig  = plic_a_address[21:3] == 19'h00210;
  assign sel_en    = (plic_a_address[21:12] == 10'h002) && (plic_a_address[6:3] == 4'h0) &&
                     (int'(en_ctx) < NCTX);
  assign sel_thr   = (plic_a_address[21:15] == 7'h40) && (plic_a_address[11:0] == 12'h000) &&
                     (int'(th_ctx) < NCTX);
  assign sel_claim = (plic_a_address[21:15] == 7'h40) && (plic_a_address[11:0] == 12'h004) &&
                     (int'(th_ctx) < NCTX);

  assign readable = sel_prio || sel_pend || sel_trig || sel_en || sel_thr || sel_claim;
`ifdef PLIC_EDGE_TRIGGER_EN
  assign writable = sel_prio || sel_trig || sel_en || sel_thr || sel_claim;
`else
  assign writable = sel_prio || sel_en || sel_thr || sel_claim;
`endif
  assign denied = is_get ? !(req_ok && readable)
                         : !(is_put && req_ok && writable && (plic_a_mask == 4'hF));

  assign wr       = accept && !denied && is_put;
  assign rd_claim = accept && !denied && is_get && sel_claim;
  assign cmpl     = wr && sel_claim;

  // Merge one 32-bit word of a per-id bit vector into the stored vector
  function automatic logic [NSRC:1] merge_word(input logic [NSRC:1] old, input logic hi,
                                               input logic [31:0] d);
    logic [NSRC:1] r;
    r = old;
    for (int i = 1; i <= NSRC; i++) begin
      if (hi == (i >= 32)) r[i] = d[i % 32];
    end
    return r;
  endfunction

  // Select the per-id and per-context views addressed by the current A beat
  always_comb begin
    prio_sel = '0;
    thr_sel  = '0;
    claim_id = '0;
    cmpl_en  = '0;
    en64     = '0;
    pend64   = 64'({pend_q, 1'b0});
`ifdef PLIC_EDGE_TRIGGER_EN
    trig64   = 64'({trig_q, 1'b0});
`else
    trig64   = '0;
`endif
    for (int i = 1; i <= NSRC; i++) begin
      if (int'(prio_id) == i) prio_sel = prio_q[i];
    end
    for (int c = 0; c < NCTX; c++) begin
      if (int'(en_ctx) == c) en64 = 64'({en_q[c], 1'b0});
      if (int'(th_ctx) == c) begin
        thr_sel  = thr_q[c];
        claim_id = best_id_q[c];
        cmpl_en  = en_q[c];
      end
    end
  end

  // Read data mux
  always_comb begin
    rdata = '0;
    if (sel_prio)       rdata = 32'(prio_sel);
    else if (sel_pend)  rdata = hi_word ? pend64[63:32] : pend64[31:0];
    else if (sel_trig)  rdata = hi_word ? trig64[63:32] : trig64[31:0];
    else if (sel_en)    rdata = hi_word ? en64[63:32] : en64[31:0];
    else if (sel_thr)   rdata = 32'(thr_sel);
    else if (sel_claim) rdata = 32'(claim_id);
  end

  // Per-id claim and complete strobes for this cycle
  always_comb begin
    claim_hit = '0;
    cmpl_hit  = '0;
    for (int i = 1; i <= NSRC; i++) begin
      claim_hit[i] = rd_claim && (int'(claim_id) == i);
      cmpl_hit[i]  = cmpl && (int'(cmpl_id) == i) && serv_q[i] && cmpl_en[i];
    end
  end

`ifdef PLIC_EDGE_TRIGGER_EN
  assign rise = int_i & ~int_prev_q;
`endif

  // Gateway next state: IDLE (neither bit), PEND, SERV
  always_comb begin
    pend_d = pend_q;
    serv_d = serv_q;
`ifdef PLIC_EDGE_TRIGGER_EN
    defer_d = defer_q;
`endif
    for (int i = 1; i <= NSRC; i++) begin
`ifdef PLIC_EDGE_TRIGGER_EN
      if (trig_q[i]) begin
        if (cmpl_hit[i]) begin
          serv_d[i]  = 1'b0;
          pend_d[i]  = defer_q[i] || rise[i-1];
          defer_d[i] = 1'b0;
        end else if (claim_hit[i] && pend_q[i]) begin
          pend_d[i] = 1'b0;
          serv_d[i] = 1'b1;
          if (rise[i-1]) defer_d[i] = 1'b1;
        end else if (!pend_q[i] && !serv_q[i]) begin
          pend_d[i] = rise[i-1];
        end else if (rise[i-1]) begin
          defer_d[i] = 1'b1;
        end
      end else begin
        defer_d[i] = 1'b0;
`else
      begin
`endif
        if (cmpl_hit[i]) begin
          serv_d[i] = 1'b0;
        end else if (claim_hit[i] && pend_q[i]) begin
          pend_d[i] = 1'b0;
          serv_d[i] = 1'b1;
        end else if (!pend_q[i] && !serv_q[i]) begin
          pend_d[i] = int_i[i-1];
        end
      end
    end
  end

  // Max-priority search per context; an id being claimed now is excluded everywhere
  always_comb begin
    for (int c = 0; c < NCTX; c++) begin
      best_id_d[c] = '0;
      best_pr_d[c] = '0;
      for (int i = 1; i <= NSRC; i++) begin
        if (pend_q[i] && !claim_hit[i] && en_q[c][i] && (prio_q[i] > best_pr_d[c])) begin
          best_pr_d[c] = prio_q[i];
          best_id_d[c] = 6'(i);
        end
      end
    end
  end

  // Software-visible configuration registers
  always_ff @(posedge plic_clock_i or negedge plic_reset_ni) begin
    if (!plic_reset_ni) begin
      for (int i = 1; i <= NSRC; i++) prio_q[i] <= '0;
      for (int c = 0; c < NCTX; c++) begin
        en_q[c]  <= '0;
        thr_q[c] <= '0;
      end
    end else if (wr) begin
      for (int i = 1; i <= NSRC; i++) begin
        if (sel_prio && (int'(prio_id) == i)) prio_q[i] <= plic_a_data[PRIO_W-1:0];
      end
      for (int c = 0; c < NCTX; c++) begin
        if (sel_en && (int'(en_ctx) == c)) en_q[c] <= merge_word(en_q[c], hi_word, plic_a_data);
        if (sel_thr && (int'(th_ctx) == c)) thr_q[c] <= plic_a_data[PRIO_W-1:0];
      end
    end
  end

`ifdef PLIC_EDGE_TRIGGER_EN
  // Trigger-type register, deferred-edge flags and edge-detect history
  always_ff @(posedge plic_clock_i or negedge plic_reset_ni) begin
    if (!plic_reset_ni) begin
      trig_q     <= '0;
      defer_q    <= '0;
      int_prev_q <= '0;
    end else begin
      if (wr && sel_trig) trig_q <= merge_word(trig_q, hi_word, plic_a_data);
      defer_q    <= defer_d;
      int_prev_q <= int_i;
    end
  end
`endif

  // Gateway state and registered arbitration result
  always_ff @(posedge plic_clock_i or negedge plic_reset_ni) begin
    if (!plic_reset_ni) begin
      pend_q <= '0;
      serv_q <= '0;
      for (int c = 0; c < NCTX; c++) begin
        best_id_q[c] <= '0;
        best_pr_q[c] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      serv_q <= serv_d;
      for (int c = 0; c < NCTX; c++) begin
        best_id_q[c] <= best_id_d[c];
        best_pr_q[c] <= best_pr_d[c];
      end
    end
  end

  // Single D-channel response slot, loaded on every accepted A beat
  always_ff @(posedge plic_clock_i or negedge plic_reset_ni) begin
    if (!plic_reset_ni) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_denied_q <= 1'b0;
      d_data_q   <= '0;
    end else if (accept) begin
      d_valid_q  <= 1'b1;
      d_opcode_q <= is_get ? OP_ACK_DATA : OP_ACK;
      d_size_q   <= plic_a_size;
      d_source_q <= plic_a_source;
      d_denied_q <= denied;
      d_data_q   <= (is_get && !denied) ? rdata : 32'h0;
    end else if (plic_d_ready) begin
      d_valid_q  <= 1'b0;
    end
  end

  // Notification: registered best priority strictly above the context threshold
  always_comb begin
    int_o = '0;
    for (int c = 0; c < NCTX; c++) int_o[c] = best_pr_q[c] > thr_q[c];
  end

  assign plic_d_valid   = d_valid_q;
  assign plic_d_opcode  = d_opcode_q;
  assign plic_d_param   = 2'b00;
  assign plic_d_size    = d_size_q;
  assign plic_d_source  = d_source_q;
  assign plic_d_denied  = d_denied_q;
  assign plic_d_data    = d_data_q;
  assign plic_d_corrupt = 1'b0;

endmodule

// File: tb/tb_polaris_plic_gen2.sv
// tb/tb_polaris_plic_gen2.sv - scoreboard testbench for polaris_plic_gen2
`timescale 1ns/1ps
module tb_polaris_plic_gen2;
  localparam int TL_RS = 4, NSRC = 31, NCTX = 2, PRIO_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       a_opcode, a_param;
  logic [3:0]       a_size, a_mask;
  logic [TL_RS-1:0] a_source;
  logic [21:0]      a_address;
  logic [31:0]      a_data;
  logic             a_corrupt, a_valid, a_ready;
  logic [2:0]       d_opcode;
  logic [1:0]       d_param;
  logic [3:0]       d_size;
  logic [TL_RS-1:0] d_source;
  logic             d_denied, d_corrupt, d_valid, d_ready;
  logic [31:0]      d_data;
  logic [NSRC-1:0]  int_src;
  logic [NCTX-1:0]  int_out;

  polaris_plic_gen2 #(.TL_RS(TL_RS), .NSRC(NSRC), .NCTX(NCTX), .PRIO_W(PRIO_W)) dut (
    .plic_clock_i(clk), .plic_reset_ni(rst_n),
    .plic_a_opcode(a_opcode), .plic_a_param(a_param), .plic_a_size(a_size),
    .plic_a_source(a_source), .plic_a_address(a_address), .plic_a_mask(a_mask),
    .plic_a_data(a_data), .plic_a_corrupt(a_corrupt), .plic_a_valid(a_valid),
    .plic_a_ready(a_ready),
    .plic_d_opcode(d_opcode), .plic_d_param(d_param), .plic_d_size(d_size),
    .plic_d_source(d_source), .plic_d_denied(d_denied), .plic_d_data(d_data),
    .plic_d_corrupt(d_corrupt), .plic_d_valid(d_valid), .plic_d_ready(d_ready),
    .int_i(int_src), .int_o(int_out)
  );

  typedef struct {
    logic [31:0]      data;
    logic             denied;
    logic [2:0]       op;
    logic [TL_RS-1:0] src;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  logic [TL_RS-1:0] src_ctr = '0;

  localparam logic [21:0] PEND = 22'h001000, TRIG = 22'h001080, EN0 = 22'h002000;
  localparam logic [21:0] THR0 = 22'h200000, CLM0 = 22'h200004;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completed D beat is checked against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && d_valid && d_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_d_beat: got data %0h expected no beat", d_data);
      end else begin
        mon_e = sb.pop_front();
        chk("d_data", d_data, mon_e.data);
        chk("d_denied", 32'(d_denied), 32'(mon_e.denied));
        chk("d_opcode", 32'(d_opcode), 32'(mon_e.op));
        chk("d_source", 32'(d_source), 32'(mon_e.src));
      end
    end
  end

  task automatic tl_push(input logic [2:0] op, input logic [21:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [31:0] exp_data, input logic exp_den);
    exp_t e;
    e.data = exp_data;
    e.denied = exp_den;
    e.op = (op == 3'd4) ? 3'd1 : 3'd0;
    e.src = src_ctr;
    sb.push_back(e);
    a_opcode = op; a_address = addr; a_data = data; a_mask = mask;
    a_source = src_ctr; a_valid = 1'b1;
  endtask

  task automatic tl(input logic [2:0] op, input logic [21:0] addr, input logic [31:0] data,
                    input logic [3:0] mask, input logic [31:0] exp_data, input logic exp_den);
    int n;
    tl_push(op, addr, data, mask, exp_data, exp_den);
    n = 0;
    while (!a_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL a_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    src_ctr++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic get(input logic [21:0] addr, input logic [31:0] exp_data);
    tl(3'd4, addr, 32'h0, 4'hF, exp_data, 1'b0);
  endtask

  task automatic put(input logic [21:0] addr, input logic [31:0] data);
    tl(3'd0, addr, data, 4'hF, 32'h0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    a_opcode = '0; a_param = '0; a_size = 4'd2; a_mask = 4'hF; a_source = '0;
    a_address = '0; a_data = '0; a_corrupt = 1'b0; a_valid = 1'b0;
    d_ready = 1'b1; int_src = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_int_o", 32'(int_out), 32'h0);
    chk("reset_d_valid", 32'(d_valid), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset values
    get(22'h00000C, 32'h0);
    get(EN0, 32'h0);
    get(22'h002084, 32'h0);
    get(THR0, 32'h0);
    get(22'h201000, 32'h0);
    get(CLM0, 32'h0);
    chk("reset_int_o_after", 32'(int_out), 32'h0);

    // Field widths, hardwired id 0 and denied accesses
    put(22'h000004, 32'hFFFF_FFFF);
    get(22'h000004, 32'h7);
    put(22'h000000, 32'h7);
    get(22'h000000, 32'h0);
    tl(3'd0, 22'h000080, 32'h1, 4'hF, 32'h0, 1'b1);
    tl(3'd1, 22'h000004, 32'h0, 4'h3, 32'h0, 1'b1);
    get(22'h000004, 32'h7);
    tl(3'd4, 22'h003000, 32'h0, 4'hF, 32'h0, 1'b1);
    tl(3'd4, 22'h202000, 32'h0, 4'hF, 32'h0, 1'b1);
    tl(3'd2, 22'h00000C, 32'h0, 4'hF, 32'h0, 1'b1);
    put(22'h000004, 32'h0);

    // Arbitration: ids 3 (prio 2) and 5 (prio 5) on context 0
    put(22'h00000C, 32'h2);
    put(22'h000014, 32'h5);
    put(EN0, 32'h28);
    get(22'h000014, 32'h5);
    get(EN0, 32'h28);
    int_src = 31'h14;
    @(posedge clk);
    @(negedge clk);
    chk("int_o_one_cycle", 32'(int_out), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("int_o_two_cycles", 32'(int_out), 32'h1);
    @(posedge clk); #1;
    get(PEND, 32'h28);
    get(CLM0, 32'h5);
    get(CLM0, 32'h3);
    get(CLM0, 32'h0);
    chk("int_o_all_claimed", 32'(int_out), 32'h0);
    int_src = '0;
    put(CLM0, 32'h5);
    put(CLM0, 32'h3);
    get(PEND, 32'h0);

    // Threshold masks notification but not claim
    put(THR0, 32'h5);
    get(THR0, 32'h5);
    int_src = 31'h10;
    repeat (3) @(posedge clk);
    #1;
    chk("int_o_thresh", 32'(int_out), 32'h0);
    get(PEND, 32'h20);
    get(CLM0, 32'h5);
    int_src = '0;
    put(CLM0, 32'h5);
    put(THR0, 32'h0);

    // Level source 7: claim, bogus complete, real complete re-pends
    put(22'h00001C, 32'h1);
    put(EN0, 32'hA8);
    int_src = 31'h40;
    repeat (3) @(posedge clk);
    #1;
    chk("int_o_id7", 32'(int_out), 32'h1);
    get(CLM0, 32'h7);
    chk("int_o_id7_serv", 32'(int_out), 32'h0);
    put(CLM0, 32'h9);
    get(PEND, 32'h0);
    chk("int_o_bad_complete", 32'(int_out), 32'h0);
    put(CLM0, 32'h7);
    chk("int_o_id7_again", 32'(int_out), 32'h1);
    get(PEND, 32'h80);
    get(CLM0, 32'h7);
    int_src = '0;
    put(CLM0, 32'h7);

    // Back-to-back Gets under D backpressure
    d_ready = 1'b0;
    get(22'h000014, 32'h5);
    tl_push(3'd4, 22'h00000C, 32'h0, 4'hF, 32'h2, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_a_ready", 32'(a_ready), 32'h0);
      chk("bp_d_valid", 32'(d_valid), 32'h1);
      chk("bp_d_data", d_data, 32'h5);
      chk("bp_d_source", 32'(d_source), 32'(src_ctr - 4'd1));
    end
    d_ready = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    src_ctr++;
    repeat (3) @(posedge clk);
    #1;

`ifdef PLIC_EDGE_TRIGGER_EN
    // Edge source 2: pulses during service defer exactly one re-pend
    put(TRIG, 32'h4);
    get(TRIG, 32'h4);
    put(22'h000008, 32'h3);
    put(EN0, 32'h4);
    int_src = 31'h2;
    @(posedge clk); #1;
    int_src = '0;
    repeat (3) @(posedge clk);
    #1;
    get(CLM0, 32'h2);
    repeat (2) begin
      int_src = 31'h2;
      @(posedge clk); #1;
      int_src = '0;
      @(posedge clk); #1;
    end
    get(PEND, 32'h0);
    put(CLM0, 32'h2);
    get(PEND, 32'h4);
    get(CLM0, 32'h2);
    get(CLM0, 32'h0);
    put(CLM0, 32'h2);
`else
    get(TRIG, 32'h0);
    tl(3'd0, TRIG, 32'h4, 4'hF, 32'h0, 1'b1);
`endif

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/polaris_plic_gen2.md
# polaris_plic_gen2

Parametrised second-generation platform-level interrupt controller on a TileLink-UL slave port. Supports NSRC sources, NCTX hart contexts, PRIO_W-bit priorities with threshold compare, per-source gateways and registered max-priority arbitration. Sits behind the system crossbar in place of the fixed 31-source/2-context, 1-bit-priority controller; `int_o` drives the external-interrupt inputs of the harts.

## Interface
- `TL_RS`, 4, TileLink source ID width
- `NSRC`, 31, interrupt sources (ids 1..NSRC, 1..63); id 0 reserved
- `NCTX`, 2, contexts (1..8)
- `PRIO_W`, 3, priority/threshold width (1..7)

- `plic_clock_i` in 1: clock
- `plic_reset_ni` in 1: reset, asynchronous, active-low
- `plic_a_opcode/param/size/source/address/mask/data/corrupt/valid` in 3/3/4/TL_RS/22/4/32/1/1: TL-A channel
- `plic_a_ready` out 1: A accept
- `plic_d_opcode/param/size/source/denied/data/corrupt/valid` out 3/2/4/TL_RS/1/32/1/1: TL-D channel
- `plic_d_ready` in 1: D accept
- `int_i` in NSRC: source lines, bit k-1 = id k, synchronous to clock
- `int_o` out NCTX: per-context interrupt notification

## Operation
- Map (word offsets): priority[id] 0x000000+4·id; pending 0x001000 (ids 0..31) and 0x001004 (32..63), RO; enable[ctx] 0x002000+0x80·ctx (+4 upper word); threshold[ctx] 0x200000+0x1000·ctx; claim/complete[ctx] +0x004.
- Accepted opcodes: Get(4)→AccessAckData(1); PutFull(0)/PutPartial(1)→AccessAck(0). Puts with mask≠4'hF, unmapped addresses, id>NSRC or ctx≥NCTX: `denied`=1, data 0, no side effect. Other opcodes: denied.
- Fields wider than PRIO_W/NSRC read as zero, writes ignored; priority[0] and enable bit 0 hardwired 0.
- Gateway per id, state IDLE→PEND→SERV→IDLE. Level: IDLE&int_i→PEND. Claim of id: PEND→SERV, pending cleared. Complete of id: SERV→IDLE; if still asserted, PEND next cycle.
- Arbitration per context: candidates = PEND & enable[ctx] & priority>0; pick max priority, ties → lowest id; result registered (best_id, best_prio).
- `int_o[ctx]` = registered (best_prio > threshold[ctx]).
- Claim read returns registered best_id (0 if none) and moves it to SERV; threshold does not gate claim.
- Complete write: data[5:0] = id; acts only if id in SERV and enable[ctx][id]=1, else silently ignored (AccessAck, not denied).

## Timing
- Reset: all priorities, enables, thresholds 0; all gateways IDLE; `plic_d_valid`=0, `int_o`=0; other D outputs 0.
- Single response register: `plic_a_ready` = !d_valid | d_ready; A beat in cycle N → D valid in N+1, held until d_ready.
- Register writes, claim, complete take effect at end of accept cycle; arbitration reflects them one cycle later; `int_o` two cycles after int_i rise.
- Claim of id and same-cycle complete of another: both apply. Claim of id clears it from every context's next arbitration.
- Read of a just-written register in the next beat returns new value.
- Reset asserted mid-transaction: D beat dropped, all state returns to reset values immediately.

## Configuration
- `PLIC_EDGE_TRIGGER_EN`: adds trigger-type register at 0x001080 (+4), bit id=1 edge. Edge source: rising edge in IDLE→PEND; rising edge while PEND/SERV sets one-deep deferred flag, which moves gateway to PEND on complete. Without macro: register absent (reads 0, writes denied), all sources level, no edge detectors.

## Test plan
- Reset → all reads of priority/enable/threshold 0, `int_o`=0, claim returns 0.
- prio[3]=2, prio[5]=5, enable ctx0 ids 3,5, thresh0=0, raise int_i ids 3,5 → int_o[0]=1 in 2 cycles; claim → 5, claim → 3, third claim → 0.
- thresh0=5 with prio[5]=5 → int_o[0]=0; claim still returns 5.
- Level id 7 held high, claim then complete 7 → pending re-set, int_o reasserts; complete 9 (not SERV) ignored.
- Back-to-back Gets with d_ready low 3 cycles → a_ready low, D data/source stable, no beat lost.
- With PLIC_EDGE_TRIGGER_EN: id 2 edge, two pulses during SERV → exactly one extra claim of 2 after complete.
